// File: rtl/frv_pipeline_execute_pkg.sv
// Shared widths, functional-unit/uop encodings and stage payload for the execute stage.
package frv_pipeline_execute_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned XL    = XLEN - 1;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned UOP_W = 5;
  localparam int unsigned FU_W  = 5;

  // One-hot functional unit bit positions
  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_MUL = 1;
  localparam int unsigned FU_LSU = 2;
  localparam int unsigned FU_CFU = 3;
  localparam int unsigned FU_CSR = 4;

  // LSU uops with this bit set are stores; otherwise loads
  localparam int unsigned LSU_STORE_BIT = 4;

  localparam logic [UOP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [UOP_W-1:0] ALU_SUB  = 5'd1;
  localparam logic [UOP_W-1:0] ALU_AND  = 5'd2;
  localparam logic [UOP_W-1:0] ALU_OR   = 5'd3;
  localparam logic [UOP_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [UOP_W-1:0] ALU_SLT  = 5'd5;
  localparam logic [UOP_W-1:0] ALU_SLTU = 5'd6;
  localparam logic [UOP_W-1:0] ALU_SLL  = 5'd7;
  localparam logic [UOP_W-1:0] ALU_SRL  = 5'd8;
  localparam logic [UOP_W-1:0] ALU_SRA  = 5'd9;

  localparam logic [UOP_W-1:0] MUL_MUL    = 5'd0;
  localparam logic [UOP_W-1:0] MUL_MULH   = 5'd1;
  localparam logic [UOP_W-1:0] MUL_MULHSU = 5'd2;
  localparam logic [UOP_W-1:0] MUL_MULHU  = 5'd3;
  localparam logic [UOP_W-1:0] MUL_DIV    = 5'd4;
  localparam logic [UOP_W-1:0] MUL_DIVU   = 5'd5;
  localparam logic [UOP_W-1:0] MUL_REM    = 5'd6;
  localparam logic [UOP_W-1:0] MUL_REMU   = 5'd7;

  localparam logic [UOP_W-1:0] CFU_BEQ  = 5'd0;
  localparam logic [UOP_W-1:0] CFU_BNE  = 5'd1;
  localparam logic [UOP_W-1:0] CFU_BLT  = 5'd2;
  localparam logic [UOP_W-1:0] CFU_BGE  = 5'd3;
  localparam logic [UOP_W-1:0] CFU_BLTU = 5'd4;
  localparam logic [UOP_W-1:0] CFU_BGEU = 5'd5;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;

  typedef struct packed {
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  wdata;
    logic [XLEN-1:0]  opr_b;
    logic [XLEN-1:0]  opr_c;
    logic [31:0]      pc;
    logic [UOP_W-1:0] uop;
    logic [FU_W-1:0]  fu;
    logic             trap;
    logic [1:0]       size;
    logic [31:0]      instr;
    logic             taken;
  } s4_payload_t;

endpackage

// File: rtl/frv_muldiv_iter.sv
// Iterative multiplier/divider: 32 shift-add or restoring-subtract steps on magnitudes,
// sign fix-up applied combinationally while DONE.
module frv_muldiv_iter
  import frv_pipeline_execute_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             ack,
  input  logic [UOP_W-1:0] uop,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             done_c,
  output logic [XLEN-1:0]  result_c
);

  md_state_e         state;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand;
  logic              is_div, want_hi, neg;

  logic              sgn_a, sgn_b, a_neg, b_neg, is_div_d, want_hi_d, neg_d;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_sum, rem_hi;
  logic [XLEN-1:0]   sub_diff, sel;
  logic              rem_ge;
  logic [2*XLEN-1:0] acc_step, prod;

  // Decode signedness and strip operand signs for a new operation
  always_comb begin
    sgn_a     = (uop == MUL_MULH) || (uop == MUL_MULHSU) || (uop == MUL_DIV) || (uop == MUL_REM);
    sgn_b     = (uop == MUL_MULH) || (uop == MUL_DIV) || (uop == MUL_REM);
    a_neg     = sgn_a && a[XL];
    b_neg     = sgn_b && b[XL];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    is_div_d  = uop[2];
    want_hi_d = is_div_d ? uop[1] : (uop != MUL_MUL);
    if (!is_div_d)  neg_d = a_neg ^ b_neg;
    else if (uop[1]) neg_d = a_neg;
    else            neg_d = (a_neg ^ b_neg) && (b != '0);
  end

  // One multiply or divide step on the accumulator
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_hi   = acc[2*XLEN-1:XLEN-1];
    rem_ge   = rem_hi >= {1'b0, operand};
    sub_diff = rem_hi[XL:0] - operand;
    if (!is_div)     acc_step = {add_sum, acc[XL:1]};
    else if (rem_ge) acc_step = {sub_diff, acc[XLEN-2:0], 1'b1};
    else             acc_step = {rem_hi[XL:0], acc[XLEN-2:0], 1'b0};
  end

  // Sign fix-up and high/low selection of the finished result
  always_comb begin
    prod     = neg ? -acc : acc;
    sel      = want_hi ? acc[2*XLEN-1:XLEN] : acc[XL:0];
    result_c = '0;
    if (is_div)       result_c = neg ? -sel : sel;
    else if (want_hi) result_c = prod[2*XLEN-1:XLEN];
    else              result_c = prod[XL:0];
  end

  assign done_c = (state == MD_DONE);

  // IDLE -> RUN -> DONE -> IDLE sequencer; flush aborts at any point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      want_hi <= 1'b0;
      neg     <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state   <= MD_RUN;
          cnt     <= 5'd31;
          acc     <= {{XLEN{1'b0}}, (is_div_d ? a_mag : b_mag)};
          operand <= is_div_d ? b_mag : a_mag;
          is_div  <= is_div_d;
          want_hi <= want_hi_d;
          neg     <= neg_d;
        end
        MD_RUN: begin
          acc <= acc_step;
          if (cnt == 5'd0) state <= MD_DONE;
          else             cnt   <= cnt - 5'd1;
        end
        MD_DONE: if (ack) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/frv_pipeline_execute.sv
// Backend execute stage: single-cycle ALU/LSU/CSR/CFU, iterative MUL/DIV, registered stage-4 output.
module frv_pipeline_execute
  import frv_pipeline_execute_pkg::*;
(
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             s3_p_valid,
  output logic             s3_p_busy,
  input  logic [RD_W-1:0]  s3_rd,
  input  logic [XLEN-1:0]  s3_opr_a,
  input  logic [XLEN-1:0]  s3_opr_b,
  input  logic [XLEN-1:0]  s3_opr_c,
  input  logic [31:0]      s3_pc,
  input  logic [UOP_W-1:0] s3_uop,
  input  logic [FU_W-1:0]  s3_fu,
  input  logic             s3_trap,
  input  logic [1:0]       s3_size,
  input  logic [31:0]      s3_instr,
  input  logic             flush,
  output logic [RD_W-1:0]  fwd_s3_rd,
  output logic [XLEN-1:0]  fwd_s3_wdata,
  output logic             fwd_s3_load,
  output logic             fwd_s3_csr,
  output logic             s4_p_valid,
  input  logic             s4_p_busy,
  output logic [RD_W-1:0]  s4_rd,
  output logic [XLEN-1:0]  s4_wdata,
  output logic [XLEN-1:0]  s4_opr_b,
  output logic [XLEN-1:0]  s4_opr_c,
  output logic             s4_taken,
  output logic [31:0]      s4_pc,
  output logic [UOP_W-1:0] s4_uop,
  output logic [FU_W-1:0]  s4_fu,
  output logic             s4_trap,
  output logic [1:0]       s4_size,
  output logic [31:0]      s4_instr
);

  logic            p_busy, mul_op, accept, md_done, taken;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result, md_result, result;
  s4_payload_t     s4_q, s4_d;

  // Trapping MUL-unit ops bypass the iterative unit
  assign mul_op    = s3_p_valid && s3_fu[FU_MUL] && !s3_trap;
  assign p_busy    = s4_p_valid && s4_p_busy;
  assign s3_p_busy = p_busy || (mul_op && !md_done);
  assign accept    = s3_p_valid && !s3_p_busy;
  assign shamt     = s3_opr_b[4:0];

  frv_muldiv_iter u_muldiv (
    .clk      (g_clk),
    .rst      (g_reset),
    .start    (mul_op && !flush),
    .flush    (flush),
    .ack      (accept),
    .uop      (s3_uop),
    .a        (s3_opr_a),
    .b        (s3_opr_b),
    .done_c   (md_done),
    .result_c (md_result)
  );

  // Single-cycle ALU
  always_comb begin
    alu_result = '0;
    case (s3_uop)
      ALU_ADD:  alu_result = s3_opr_a + s3_opr_b;
      ALU_SUB:  alu_result = s3_opr_a - s3_opr_b;
      ALU_AND:  alu_result = s3_opr_a & s3_opr_b;
      ALU_OR:   alu_result = s3_opr_a | s3_opr_b;
      ALU_XOR:  alu_result = s3_opr_a ^ s3_opr_b;
      ALU_SLT:  alu_result = {{XL{1'b0}}, ($signed(s3_opr_a) < $signed(s3_opr_b))};
      ALU_SLTU: alu_result = {{XL{1'b0}}, (s3_opr_a < s3_opr_b)};
      ALU_SLL:  alu_result = s3_opr_a << shamt;
      ALU_SRL:  alu_result = s3_opr_a >> shamt;
      ALU_SRA:  alu_result = $signed(s3_opr_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  // Conditional branch resolution
  always_comb begin
    taken = 1'b0;
    case (s3_uop)
      CFU_BEQ:  taken = (s3_opr_a == s3_opr_b);
      CFU_BNE:  taken = (s3_opr_a != s3_opr_b);
      CFU_BLT:  taken = ($signed(s3_opr_a) < $signed(s3_opr_b));
      CFU_BGE:  taken = !($signed(s3_opr_a) < $signed(s3_opr_b));
      CFU_BLTU: taken = (s3_opr_a < s3_opr_b);
      CFU_BGEU: taken = !(s3_opr_a < s3_opr_b);
      default:  taken = 1'b0;
    endcase
    taken = taken && s3_fu[FU_CFU] && !s3_trap;
  end

  // Result select by functional unit
  always_comb begin
    result = '0;
    if (s3_trap)             result = s3_opr_a;
    else if (s3_fu[FU_ALU])  result = alu_result;
    else if (s3_fu[FU_LSU])  result = s3_opr_a + s3_opr_b;
    else if (s3_fu[FU_CSR])  result = s3_opr_a;
    else if (s3_fu[FU_MUL])  result = md_result;
  end

  assign fwd_s3_rd    = s3_p_valid ? s3_rd : '0;
  assign fwd_s3_wdata = result;
  assign fwd_s3_load  = s3_p_valid && ((s3_fu[FU_LSU] && !s3_uop[LSU_STORE_BIT]) ||
                                       (mul_op && !md_done));
  assign fwd_s3_csr   = s3_p_valid && s3_fu[FU_CSR];

  // Payload captured into the stage-4 register
  always_comb begin
    s4_d       = '0;
    s4_d.rd    = s3_rd;
    s4_d.wdata = result;
    s4_d.opr_b = s3_opr_b;
    s4_d.opr_c = s3_opr_c;
    s4_d.pc    = s3_pc;
    s4_d.uop   = s3_uop;
    s4_d.fu    = s3_fu;
    s4_d.trap  = s3_trap;
    s4_d.size  = s3_size;
    s4_d.instr = s3_instr;
    s4_d.taken = taken;
  end

  // Stage-4 output register: holds under stall, flush invalidates
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      s4_p_valid <= 1'b0;
      s4_q       <= '0;
    end else if (flush) begin
      s4_p_valid <= 1'b0;
    end else if (!p_busy) begin
      s4_p_valid <= accept;
      if (accept) s4_q <= s4_d;
    end
  end

  assign s4_rd    = s4_q.rd;
  assign s4_wdata = s4_q.wdata;
  assign s4_opr_b = s4_q.opr_b;
  assign s4_opr_c = s4_q.opr_c;
  assign s4_taken = s4_q.taken;
  assign s4_pc    = s4_q.pc;
  assign s4_uop   = s4_q.uop;
  assign s4_fu    = s4_q.fu;
  assign s4_trap  = s4_q.trap;
  assign s4_size  = s4_q.size;
  assign s4_instr = s4_q.instr;

endmodule

// File: tb/tb_frv_pipeline_execute.sv
// Directed bench for the execute stage: ALU/LSU/CSR/CFU, iterative MUL/DIV, flush, stall, reset.
module tb_frv_pipeline_execute;
  import frv_pipeline_execute_pkg::*;

  logic        g_clk, g_reset;
  logic        s3_p_valid, s3_p_busy;
  logic [4:0]  s3_rd;
  logic [31:0] s3_opr_a, s3_opr_b, s3_opr_c, s3_pc;
  logic [4:0]  s3_uop, s3_fu;
  logic        s3_trap;
  logic [1:0]  s3_size;
  logic [31:0] s3_instr;
  logic        flush;
  logic [4:0]  fwd_s3_rd;
  logic [31:0] fwd_s3_wdata;
  logic        fwd_s3_load, fwd_s3_csr;
  logic        s4_p_valid, s4_p_busy;
  logic [4:0]  s4_rd;
  logic [31:0] s4_wdata, s4_opr_b, s4_opr_c;
  logic        s4_taken;
  logic [31:0] s4_pc;
  logic [4:0]  s4_uop, s4_fu;
  logic        s4_trap;
  logic [1:0]  s4_size;
  logic [31:0] s4_instr;

  int checks = 0;
  int errors = 0;

  frv_pipeline_execute dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s3_p_valid(s3_p_valid), .s3_p_busy(s3_p_busy), .s3_rd(s3_rd),
    .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b), .s3_opr_c(s3_opr_c),
    .s3_pc(s3_pc), .s3_uop(s3_uop), .s3_fu(s3_fu), .s3_trap(s3_trap),
    .s3_size(s3_size), .s3_instr(s3_instr), .flush(flush),
    .fwd_s3_rd(fwd_s3_rd), .fwd_s3_wdata(fwd_s3_wdata),
    .fwd_s3_load(fwd_s3_load), .fwd_s3_csr(fwd_s3_csr),
    .s4_p_valid(s4_p_valid), .s4_p_busy(s4_p_busy), .s4_rd(s4_rd),
    .s4_wdata(s4_wdata), .s4_opr_b(s4_opr_b), .s4_opr_c(s4_opr_c),
    .s4_taken(s4_taken), .s4_pc(s4_pc), .s4_uop(s4_uop), .s4_fu(s4_fu),
    .s4_trap(s4_trap), .s4_size(s4_size), .s4_instr(s4_instr)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] fu1h(input int unsigned idx);
    return 5'(1) << idx;
  endfunction

  task automatic present(input logic [4:0] fu, input logic [4:0] uop,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    s3_p_valid = 1'b1;
    s3_fu      = fu;
    s3_uop     = uop;
    s3_opr_a   = a;
    s3_opr_b   = b;
    s3_opr_c   = 32'h0000_0C00;
    s3_rd      = rd;
    s3_trap    = 1'b0;
    s3_pc      = 32'h0000_1000;
    s3_size    = 2'd2;
    s3_instr   = 32'h0000_0013;
  endtask

  // Single-cycle op: check forwarded result, then registered result
  task automatic op1(input string tag, input int unsigned fu, input logic [4:0] uop,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    present(fu1h(fu), uop, a, b, 5'd1);
    #1 chk({tag, "_fwd"}, fwd_s3_wdata, exp);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1 chk({tag, "_s4"}, s4_wdata, exp);
  endtask

  task automatic branch(input string tag, input logic [4:0] uop,
                        input logic [31:0] a, input logic [31:0] b, input logic exp);
    present(fu1h(FU_CFU), uop, a, b, 5'd0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1 chk1(tag, s4_taken, exp);
  endtask

  // Iterative op: busy/load while running, 33 edges start-to-done, result on accept
  task automatic run_md(input string tag, input logic [4:0] uop,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    present(fu1h(FU_MUL), uop, a, b, 5'd9);
    #1;
    chk1({tag, "_busy"}, s3_p_busy, 1'b1);
    chk1({tag, "_load"}, fwd_s3_load, 1'b1);
    n = 0;
    while (s3_p_busy && n < 100) begin
      @(negedge g_clk);
      #1 n++;
    end
    chk({tag, "_cycles"}, 32'(n), 32'd33);
    chk1({tag, "_load_done"}, fwd_s3_load, 1'b0);
    chk({tag, "_fwd"}, fwd_s3_wdata, exp);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1;
    chk1({tag, "_s4v"}, s4_p_valid, 1'b1);
    chk({tag, "_s4"}, s4_wdata, exp);
  endtask

  initial begin
    g_reset    = 1'b1;
    s3_p_valid = 1'b0;
    s3_rd = '0; s3_opr_a = '0; s3_opr_b = '0; s3_opr_c = '0; s3_pc = '0;
    s3_uop = '0; s3_fu = '0; s3_trap = 1'b0; s3_size = '0; s3_instr = '0;
    flush = 1'b0;
    s4_p_busy = 1'b0;

    // Reset state
    #2;
    chk1("rst_s4v", s4_p_valid, 1'b0);
    chk("rst_wdata", s4_wdata, 32'h0);
    chk1("rst_busy", s3_p_busy, 1'b0);
    chk("rst_fwd_rd", 32'(fwd_s3_rd), 32'h0);
    @(negedge g_clk);
    @(negedge g_clk);
    g_reset = 1'b0;

    // ADD wraps to zero; rd forwarded during the input cycle
    present(fu1h(FU_ALU), ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd5);
    #1;
    chk("add_fwd_rd", 32'(fwd_s3_rd), 32'd5);
    chk("add_fwd_wdata", fwd_s3_wdata, 32'h0);
    chk1("add_busy", s3_p_busy, 1'b0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1;
    chk1("add_s4v", s4_p_valid, 1'b1);
    chk("add_s4_wdata", s4_wdata, 32'h0);
    chk("add_s4_rd", 32'(s4_rd), 32'd5);
    chk("idle_fwd_rd", 32'(fwd_s3_rd), 32'd0);
    @(negedge g_clk);
    chk1("add_s4v_drop", s4_p_valid, 1'b0);

    // ALU patterns
    op1("sub",  FU_ALU, ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE);
    op1("and",  FU_ALU, ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    op1("or",   FU_ALU, ALU_OR,   32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF);
    op1("xor",  FU_ALU, ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    op1("slt",  FU_ALU, ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    op1("sltu", FU_ALU, ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    op1("sll",  FU_ALU, ALU_SLL,  32'd1,         32'h0000_003F, 32'h8000_0000);
    op1("srl",  FU_ALU, ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
    op1("sra",  FU_ALU, ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);

    // LSU address wraps, load flagged for forwarding; store is not
    present(fu1h(FU_LSU), 5'h00, 32'hFFFF_FFF0, 32'h20, 5'd2);
    #1 chk1("lsu_load_fwd", fwd_s3_load, 1'b1);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1 chk("lsu_addr", s4_wdata, 32'h0000_0010);
    present(fu1h(FU_LSU), 5'h10, 32'h100, 32'h4, 5'd0);
    #1 chk1("lsu_store_fwd", fwd_s3_load, 1'b0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;

    // CSR passes A and flags csr
    present(fu1h(FU_CSR), 5'd0, 32'h1234_5678, 32'h9, 5'd3);
    #1 chk1("csr_fwd", fwd_s3_csr, 1'b1);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1;
    chk("csr_wdata", s4_wdata, 32'h1234_5678);
    chk("csr_opr_b", s4_opr_b, 32'h9);

    // Trapping MUL op passes straight through with A
    present(fu1h(FU_MUL), MUL_DIV, 32'h0000_DEAD, 32'h3, 5'd4);
    s3_trap = 1'b1;
    #1 chk1("trap_busy", s3_p_busy, 1'b0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    s3_trap = 1'b0;
    #1;
    chk("trap_wdata", s4_wdata, 32'h0000_DEAD);
    chk1("trap_flag", s4_trap, 1'b1);

    // Iterative multiply/divide
    run_md("mulhu",  MUL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md("mul",    MUL_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
    run_md("mulh",   MUL_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
    run_md("mulhsu", MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md("div_ovf", MUL_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf", MUL_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_md("remu_z", MUL_REMU,   32'd7,         32'd0,         32'd7);
    run_md("divu_z", MUL_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF);
    run_md("div_z",  MUL_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run_md("div_neg", MUL_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_md("rem_neg", MUL_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);

    // Flush mid-division returns the unit to IDLE with no output
    present(fu1h(FU_MUL), MUL_DIV, 32'd100, 32'd7, 5'd6);
    repeat (10) @(negedge g_clk);
    flush = 1'b1;
    s3_p_valid = 1'b0;
    @(negedge g_clk);
    flush = 1'b0;
    #1;
    chk1("flush_s4v", s4_p_valid, 1'b0);
    chk1("flush_busy", s3_p_busy, 1'b0);
    present(fu1h(FU_ALU), ALU_ADD, 32'd2, 32'd3, 5'd7);
    #1 chk1("post_flush_busy", s3_p_busy, 1'b0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1;
    chk1("post_flush_s4v", s4_p_valid, 1'b1);
    chk("post_flush_add", s4_wdata, 32'd5);
    run_md("divu_post_flush", MUL_DIVU, 32'd100, 32'd7, 32'd14);

    // Flush wins over accept
    present(fu1h(FU_ALU), ALU_ADD, 32'd1, 32'd1, 5'd8);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    s3_p_valid = 1'b0;
    #1 chk1("flush_vs_accept", s4_p_valid, 1'b0);

    // Stage-4 stall holds the output and back-pressures dispatch
    present(fu1h(FU_ALU), ALU_ADD, 32'd10, 32'd20, 5'd3);
    @(negedge g_clk);
    s4_p_busy = 1'b1;
    present(fu1h(FU_ALU), ALU_XOR, 32'h0000_00F0, 32'h0000_00FF, 5'd4);
    #1;
    chk1("stall_busy", s3_p_busy, 1'b1);
    chk("stall_wdata0", s4_wdata, 32'd30);
    for (int i = 0; i < 3; i++) begin
      @(negedge g_clk);
      #1;
      chk($sformatf("stall_wdata%0d", i + 1), s4_wdata, 32'd30);
      chk($sformatf("stall_rd%0d", i + 1), 32'(s4_rd), 32'd3);
      chk1($sformatf("stall_s4v%0d", i + 1), s4_p_valid, 1'b1);
      chk1($sformatf("stall_busy%0d", i + 1), s3_p_busy, 1'b1);
    end
    s4_p_busy = 1'b0;
    #1 chk1("unstall_busy", s3_p_busy, 1'b0);
    @(negedge g_clk);
    s3_p_valid = 1'b0;
    #1;
    chk("unstall_wdata", s4_wdata, 32'h0000_000F);
    chk("unstall_rd", 32'(s4_rd), 32'd4);

    // Reset mid-multiply clears outputs asynchronously
    present(fu1h(FU_MUL), MUL_MUL, 32'd3, 32'd5, 5'd9);
    repeat (5) @(negedge g_clk);
    #2;
    g_reset = 1'b1;
    s3_p_valid = 1'b0;
    #1;
    chk("rstmid_wdata", s4_wdata, 32'h0);
    chk("rstmid_rd", 32'(s4_rd), 32'h0);
    chk1("rstmid_s4v", s4_p_valid, 1'b0);
    chk1("rstmid_busy", s3_p_busy, 1'b0);
    chk1("rstmid_load", fwd_s3_load, 1'b0);
    @(negedge g_clk);
    g_reset = 1'b0;
    run_md("mul_post_rst", MUL_MUL, 32'd3, 32'd5, 32'd15);

    // Branch compares
    branch("blt",  CFU_BLT,  32'hFFFF_FFFF, 32'd1, 1'b1);
    branch("bltu", CFU_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    branch("bgeu", CFU_BGEU, 32'hFFFF_FFFF, 32'd1, 1'b1);
    branch("beq",  CFU_BEQ,  32'd3,         32'd4, 1'b0);
    branch("bne",  CFU_BNE,  32'd3,         32'd4, 1'b1);
    branch("bge",  CFU_BGE,  32'd4,         32'd4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
